// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: latches decoded ID state into EX with hold, bubble and flush.
// Optional perf counters (perf_bubbles, perf_flushes) are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipeline_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  bubble,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [5:0]            id_funct,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [5:0]            ex_funct,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_alu_src,
    output logic [ALU_OP_W-1:0]   ex_alu_op
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bubbles,
    output logic [31:0]           perf_flushes
`endif
);

    localparam int unsigned FUNCT_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     pc_plus4;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm_ext;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic [FUNCT_W-1:0]    funct;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic [ALU_OP_W-1:0]   alu_op;
    } ex_stage_t;

    ex_stage_t             ex_q, ex_d, load_c;
    logic [REG_ADDR_W-1:0] dest_c;
    logic                  ctrl_en_c;

    // Load candidate: control is gated by bubble and invalid instructions; writes to $0 are dropped.
    always_comb begin
        dest_c             = id_reg_dst ? id_rd : id_rt;
        ctrl_en_c          = id_valid && !bubble;
        load_c             = '0;
        load_c.valid       = ctrl_en_c;
        load_c.pc_plus4    = id_pc_plus4;
        load_c.rd1         = id_rd1;
        load_c.rd2         = id_rd2;
        load_c.imm_ext     = id_imm_ext;
        load_c.rs          = id_rs;
        load_c.rt          = id_rt;
        load_c.dest        = dest_c;
        load_c.funct       = id_funct;
        load_c.reg_write   = ctrl_en_c && id_reg_write && (dest_c != '0);
        load_c.mem_to_reg  = ctrl_en_c && id_mem_to_reg;
        load_c.mem_read    = ctrl_en_c && id_mem_read;
        load_c.mem_write   = ctrl_en_c && id_mem_write;
        load_c.branch      = ctrl_en_c && id_branch;
        load_c.alu_src     = ctrl_en_c && id_alu_src;
        load_c.alu_op      = ctrl_en_c ? id_alu_op : '0;

        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!hold) begin
            ex_d = load_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc_plus4   = ex_q.pc_plus4;
    assign ex_rd1        = ex_q.rd1;
    assign ex_rd2        = ex_q.rd2;
    assign ex_imm_ext    = ex_q.imm_ext;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_dest       = ex_q.dest;
    assign ex_funct      = ex_q.funct;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    // Count only actions that win the priority; saturate at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
        if (!flush && !hold && bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_bubbles = bubble_cnt_q;
    assign perf_flushes = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios plus randomized traffic vs. a rule-based model.
// Define ID_EX_PERF_CNT_EN to also exercise the perf counters.
module tb_id_ex_pipeline_reg;

    localparam int unsigned OBS_W = 158;

    logic        clk = 1'b0;
    logic        rst_n, hold, bubble, flush;
    logic        id_valid;
    logic [31:0] id_pc_plus4, id_rd1, id_rd2, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
    logic        id_branch, id_alu_src, id_reg_dst;
    logic [1:0]  id_alu_op;

    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [5:0]  ex_funct;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_alu_src;
    logic [1:0]  ex_alu_op;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_flushes;
    logic [31:0] m_bub, m_fl;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: what EX should hold after the most recent edge.
    logic        m_valid;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [5:0]  m_funct;
    logic        m_rw, m_m2r, m_mr, m_mw, m_br, m_as;
    logic [1:0]  m_aop;

    logic [OBS_W-1:0] obs;
    logic [7:0]       obs_ctrl;
    assign obs = {ex_valid, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm_ext, ex_rs, ex_rt, ex_dest,
                  ex_funct, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                  ex_branch, ex_alu_src, ex_alu_op};
    assign obs_ctrl = {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                       ex_branch, ex_alu_src, ex_alu_op};

    id_ex_pipeline_reg dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .bubble(bubble), .flush(flush),
        .id_valid(id_valid), .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_funct(ex_funct), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OBS_W-1:0] exp_vec();
        return {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_dest, m_funct,
                m_rw, m_m2r, m_mr, m_mw, m_br, m_as, m_aop};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_dest = 0; m_funct = 0;
        m_rw = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_br = 0; m_as = 0; m_aop = 0;
    endtask

    // Apply one clock edge to the model from the current inputs.
    task automatic model_edge();
        logic live;
        if (!rst_n) begin
            model_clear();
`ifdef ID_EX_PERF_CNT_EN
            m_bub = 0; m_fl = 0;
`endif
        end else if (flush) begin
            model_clear();
`ifdef ID_EX_PERF_CNT_EN
            if (m_fl != 32'hFFFF_FFFF) m_fl = m_fl + 1;
`endif
        end else if (!hold) begin
            live    = id_valid && !bubble;
            m_pc    = id_pc_plus4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm_ext;
            m_rs    = id_rs; m_rt = id_rt; m_funct = id_funct;
            m_dest  = id_reg_dst ? id_rd : id_rt;
            m_valid = live;
            m_rw    = live && id_reg_write && (m_dest != 0);
            m_m2r   = live && id_mem_to_reg;
            m_mr    = live && id_mem_read;
            m_mw    = live && id_mem_write;
            m_br    = live && id_branch;
            m_as    = live && id_alu_src;
            m_aop   = live ? id_alu_op : 2'b00;
`ifdef ID_EX_PERF_CNT_EN
            if (bubble && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
`endif
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        id_valid     = ($urandom_range(0, 7) != 0);
        id_pc_plus4  = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm_ext = $urandom;
        id_rs        = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        if ($urandom_range(0, 5) == 0) id_rt = 5'd0;
        if ($urandom_range(0, 5) == 0) id_rd = 5'd0;
        id_funct     = 6'($urandom);
        id_reg_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
        id_mem_read  = 1'($urandom); id_mem_write = 1'($urandom);
        id_branch    = 1'($urandom); id_alu_src = 1'($urandom);
        id_reg_dst   = 1'($urandom); id_alu_op = 2'($urandom);
    endtask

    task automatic ctl(input logic r, input logic h, input logic b, input logic f);
        rst_n = r; hold = h; bubble = b; flush = f;
    endtask

    task automatic test_reset();
        ctl(1'b0, 1'b1, 1'b1, 1'b0);
        id_valid = 1; id_pc_plus4 = 32'h0040_1234; id_rd1 = 32'hAAAA_5555; id_rd2 = 32'h1357_9BDF;
        id_imm_ext = 32'hFFFF_FF80; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd7; id_funct = 6'h21;
        id_reg_write = 1; id_mem_to_reg = 1; id_mem_read = 1; id_mem_write = 1;
        id_branch = 1; id_alu_src = 1; id_reg_dst = 1; id_alu_op = 2'b11;
        tick();
        n_cmp++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_all_zero: got %h want 0", obs); end
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_comb_path: ex_valid got %b want 0", ex_valid); end
        tick();
        n_cmp++;
        if (ex_pc_plus4 !== 32'h0040_1234 || ex_dest !== 5'd7 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_load: pc %h dest %0d valid %b want 00401234 7 1", ex_pc_plus4, ex_dest, ex_valid);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_first_load_all: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_load();
        rand_inputs();
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        id_imm_ext = 32'hFFFF_FF92; id_rt = 5'd9; id_rd = 5'd3; id_reg_dst = 1; id_reg_write = 1; id_valid = 1;
        tick();
        n_cmp++;
        if (ex_imm_ext !== 32'hFFFF_FF92 || ex_dest !== 5'd3 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL load_basic: imm %h dest %0d rw %b valid %b want ffffff92 3 1 1", ex_imm_ext, ex_dest, ex_reg_write, ex_valid);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL load_basic_all: got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_dest_zero();
        rand_inputs();
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        id_valid = 1; id_reg_dst = 0; id_rt = 5'd0; id_rd = 5'd12; id_reg_write = 1;
        tick();
        n_cmp++;
        if (ex_dest !== 5'd0 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL dest_zero_suppress: dest %0d rw %b want 0 0", ex_dest, ex_reg_write);
        end
        id_rt = 5'd8;
        tick();
        n_cmp++;
        if (ex_dest !== 5'd8 || ex_reg_write !== 1'b1) begin
            n_fail++; $display("FAIL dest_rt8: dest %0d rw %b want 8 1", ex_dest, ex_reg_write);
        end
    endtask

    task automatic test_bubble();
        rand_inputs();
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        n_cmp++;
        if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL bubble_lw_loaded: mem_read got %b want 1", ex_mem_read); end
        id_imm_ext = 32'h0000_BEEF;
        bubble = 1;
        tick();
        n_cmp++;
        if (obs_ctrl !== 8'h00 || ex_valid !== 1'b0 || ex_imm_ext !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL bubble_nop: ctrl %h valid %b imm %h want 00 0 0000beef", obs_ctrl, ex_valid, ex_imm_ext);
        end
        bubble = 0;
        tick();
        n_cmp++;
        if (ex_mem_read !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL bubble_resume: mem_read %b valid %b want 1 1", ex_mem_read, ex_valid);
        end
    endtask

    task automatic test_hold_flush();
        logic [OBS_W-1:0] snap;
        rand_inputs();
        id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_rd = 5'd17;
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        snap = exp_vec();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            hold = 1;
            tick();
            n_cmp++;
            if (obs !== snap) begin n_fail++; $display("FAIL hold_frozen_%0d: got %h want %h", i, obs, snap); end
        end
        flush = 1;
        tick();
        n_cmp++;
        if (obs !== '0) begin n_fail++; $display("FAIL hold_with_flush: got %h want 0", obs); end
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        rand_inputs();
        id_valid = 1;
        tick();
        snap = exp_vec();
        rand_inputs();
        hold = 1; bubble = 1;
        tick();
        n_cmp++;
        if (obs !== snap) begin n_fail++; $display("FAIL hold_with_bubble: got %h want %h", obs, snap); end
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf();
        rand_inputs();
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ctl(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin rand_inputs(); tick(); end
        ctl(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        ctl(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        ctl(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (perf_bubbles !== 32'd4 || perf_flushes !== 32'd2) begin
            n_fail++; $display("FAIL perf_counts: bubbles %0d flushes %0d want 4 2", perf_bubbles, perf_flushes);
        end
        ctl(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset: bubbles %0d flushes %0d want 0 0", perf_bubbles, perf_flushes);
        end
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst_n  = ($urandom_range(0, 40) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            hold   = ($urandom_range(0, 4) == 0);
            bubble = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec()); end
`ifdef ID_EX_PERF_CNT_EN
            n_cmp++;
            if (perf_bubbles !== m_bub || perf_flushes !== m_fl) begin
                n_fail++; $display("FAIL random_perf_%0d: got %0d/%0d want %0d/%0d", i, perf_bubbles, perf_flushes, m_bub, m_fl);
            end
`endif
        end
    endtask

    initial begin
        model_clear();
`ifdef ID_EX_PERF_CNT_EN
        m_bub = 0; m_fl = 0;
`endif
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        rand_inputs();
        #1;
        test_reset();
        test_load();
        test_dest_zero();
        test_bubble();
        test_hold_flush();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of the ID-stage sign-extension unit.
- Latches the 32-bit sign-extended immediate, register-file read data, register specifiers, PC+4 and decoded control into the EX stage.
- Implements hold (freeze), bubble (NOP insertion for load-use) and flush (branch/jump squash).
- Resolves the write-destination register one stage early.

Parameters:
- DATA_W, 32, width of data path, PC and immediate
- REG_ADDR_W, 5, register specifier width
- ALU_OP_W, 2, ALU-op control field width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- hold  in  1  freeze all ID/EX state (EX/MEM back-pressure)
- bubble  in  1  load-use stall from hazard unit; inject NOP
- flush  in  1  squash instruction entering EX (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4  in  DATA_W  PC+4 of ID instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data (rs, rt)
- id_imm_ext  in  DATA_W  sign-extended immediate from sign-extension unit
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers
- id_funct  in  6  instruction funct field
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded control
- id_alu_op  in  ALU_OP_W  ALU-op control
- ex_valid  out  1  EX holds a real instruction
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm_ext  out  DATA_W  registered copies
- ex_rs, ex_rt  out  REG_ADDR_W  registered specifiers (forwarding unit)
- ex_dest  out  REG_ADDR_W  resolved write register
- ex_funct  out  6  registered funct
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  ALU_OP_W  registered ALU-op

Behaviour:
- All state updates on the rising clk edge only. No combinational input-to-output paths.
- Per-edge priority: !rst_n > flush > hold > bubble > load.
- Reset (rst_n=0 at edge): every output is 0, including ex_valid, all control, data, ex_dest, ex_rs, ex_rt and ex_funct.
- Flush:
  - ex_valid and all control outputs (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, alu_op) are cleared to 0.
  - Data and specifier outputs are also cleared to 0.
  - Flush overrides hold and bubble asserted in the same cycle.
- Hold (no flush): every output retains its value. A bubble asserted in the same cycle is ignored; the hazard unit re-asserts it.
- Bubble (no flush/hold):
  - Control outputs and ex_valid are forced to 0.
  - Data/specifier outputs load normally (don't-care, but deterministic).
- Load:
  - Every ex_* output takes its id_* counterpart. ex_valid = id_valid.
  - ex_dest = id_reg_dst ? id_rd : id_rt.
- Zero-register suppression on load: if the resolved dest is 0, ex_reg_write = 0 regardless of id_reg_write.
- Invalid instructions on load: if id_valid=0, all control outputs load as 0.
- Latency: exactly 1 cycle, ID input to EX output.
- Reset asserted mid-stall or mid-hold clears state on that edge. The first post-reset edge with rst_n=1 performs a normal priority evaluation.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN
- Defined:
  - Adds outputs perf_bubbles and perf_flushes, each 32 bits.
  - Each counter increments by 1 on every edge where that action takes effect by priority.
  - A bubble masked by hold or flush is not counted.
  - Counters saturate at 0xFFFFFFFF, are cleared by reset, and are unaffected by hold.
- Undefined: no counters and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Reset: drive all id_* nonzero, rst_n=0 one edge -> every output 0; release, load one instruction -> values appear exactly one edge later.
- Normal load: id_imm_ext=0xFFFFFF92, id_rt=9, id_rd=3, id_reg_dst=1, id_reg_write=1, id_valid=1 -> ex_imm_ext=0xFFFFFF92, ex_dest=3, ex_reg_write=1, ex_valid=1.
- Dest $0: id_reg_dst=0, id_rt=0, id_reg_write=1 -> ex_dest=0, ex_reg_write=0; with id_rt=8 -> ex_dest=8, ex_reg_write=1.
- Bubble: load-word loaded (ex_mem_read=1); next edge bubble=1 -> all control and ex_valid 0, ex_imm_ext follows input; bubble=0 -> normal load resumes.
- Hold vs flush: hold=1 for 3 edges with changing inputs -> outputs frozen; hold=1 with flush=1 -> control and ex_valid cleared; hold=1 with bubble=1 -> outputs frozen.
- Counters (macro defined): 4 bubbles, 2 flushes, 1 bubble masked by hold -> perf_bubbles=4, perf_flushes=2; reset -> both 0.
